// File: rtl/decoder3x8_hold.sv
// Sequential 3-to-8 decoder: valid/ready intake, 2-entry FIFO, paced one-hot pulses
// of HOLD cycles separated by GAP idle cycles. Define DEC_INVCNT_EN to add inv_cnt.
module decoder3x8_hold #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] Y,
  input  logic       V,
  output logic [7:0] D,
  output logic       done,
  output logic       busy
`ifdef DEC_INVCNT_EN
  ,
  output logic [7:0] inv_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'((GAP > 0) ? GAP - 1 : 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] d_q, d_d;
  logic       rdy_q;

  logic [2:0] mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       full, empty, push, pop;
  logic [2:0] head;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_q && !full;
  assign push     = in_valid && in_ready && V;

  // NOTE: FIFO storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Y;
  end

  // NOTE: every registered state uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      rdy_q   <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rdy_q   <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        d_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          d_d     = 8'd1 << head;
          cnt_d   = HOLD_M1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (GAP > 0) begin
          d_d     = '0;
          cnt_d   = GAP_M1;
          state_d = S_GAP;
        end else if (!empty) begin
          // Back-to-back reload: the next code replaces D with no zero cycle.
          pop   = 1'b1;
          d_d   = 8'd1 << head;
          cnt_d = HOLD_M1;
        end else begin
          d_d     = '0;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        d_d = '0;
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        d_d     = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign D    = d_q;
  assign done = (state_q == S_DRIVE) && (cnt_q == 8'd0);
  assign busy = (state_q != S_IDLE) || !empty;

`ifdef DEC_INVCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             inv_cnt <= '0;
    else if (in_valid && in_ready && !V && inv_cnt != 8'hFF) inv_cnt <= inv_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_decoder3x8_hold.sv
// Directed self-checking bench for decoder3x8_hold: one HOLD=4/GAP=1 instance and one
// HOLD=2/GAP=0 instance sharing clock and reset.
module tb_decoder3x8_hold;

  logic       clk, rst_n;
  logic       a_valid, a_ready, a_v, a_done, a_busy;
  logic [2:0] a_y;
  logic [7:0] a_d;
  logic       b_valid, b_ready, b_v, b_done, b_busy;
  logic [2:0] b_y;
  logic [7:0] b_d;
`ifdef DEC_INVCNT_EN
  logic [7:0] a_inv, b_inv;
`endif

  int vectors = 0;
  int miscompares = 0;

  decoder3x8_hold #(.HOLD(4), .GAP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .Y(a_y), .V(a_v), .D(a_d), .done(a_done), .busy(a_busy)
`ifdef DEC_INVCNT_EN
    , .inv_cnt(a_inv)
`endif
  );

  decoder3x8_hold #(.HOLD(2), .GAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .Y(b_y), .V(b_v), .D(b_d), .done(b_done), .busy(b_busy)
`ifdef DEC_INVCNT_EN
    , .inv_cnt(b_inv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [2:0] codes [4] = '{3'd0, 3'd7, 3'd3, 3'd6};
  logic [7:0] exp_d [26] = '{
    8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80,
    8'h80, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h40,
    8'h40, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00};

  initial begin
    int  idx;
    logic took;

    rst_n = 1'b0;
    a_valid = 1'b0; a_y = '0; a_v = 1'b0;
    b_valid = 1'b0; b_y = '0; b_v = 1'b0;

    // Reset state
    #3;
    check("rst_d", a_d, 8'h00);
    check("rst_done", a_done, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ready", a_ready, 1'b0);
    tick(2);
    rst_n = 1'b1;
    check("rel_ready_before_edge", a_ready, 1'b0);
    tick(1);
    check("rel_ready_after_edge", a_ready, 1'b1);
    check("rel_d", a_d, 8'h00);

    // Single transfer Y=5 on instance A
    a_valid = 1'b1; a_y = 3'd5; a_v = 1'b1;
    tick(1);
    a_valid = 1'b0;
    check("single_d_E", a_d, 8'h00);
    check("single_busy_E", a_busy, 1'b1);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("single_d_hold", a_d, 8'h20);
      check("single_done", a_done, (i == 3));
      tick(1);
    end
    check("single_d_gap", a_d, 8'h00);
    check("single_busy_gap", a_busy, 1'b1);
    tick(1);
    check("single_d_idle", a_d, 8'h00);
    check("single_busy_idle", a_busy, 1'b0);

    // Back-to-back codes 0,7,3,6 with upstream holding data while not ready
    idx = 0;
    a_valid = 1'b1; a_y = codes[0]; a_v = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      took = a_valid && a_ready;
      tick(1);
      if (took) begin
        idx++;
        if (idx < 4) a_y = codes[idx];
        else         a_valid = 1'b0;
      end
      check("bb_d", a_d, exp_d[k-1]);
      check("bb_ready", a_ready, (k <= 2 || k == 8 || k >= 14));
      check("bb_onehot0", $onehot0(a_d), 1'b1);
    end
    check("bb_accepted", idx, 4);
    check("bb_busy_end", a_busy, 1'b0);

    // V=0 transfer is discarded
    a_valid = 1'b1; a_y = 3'd2; a_v = 1'b0;
    tick(1);
    a_valid = 1'b0;
    check("inv_d", a_d, 8'h00);
    check("inv_busy", a_busy, 1'b0);
    tick(1);
    check("inv_d_next", a_d, 8'h00);
    check("inv_busy_next", a_busy, 1'b0);
`ifdef DEC_INVCNT_EN
    check("inv_cnt_one", a_inv, 8'd1);
    a_valid = 1'b1;
    tick(299);
    a_valid = 1'b0;
    check("inv_cnt_sat", a_inv, 8'd255);
    check("inv_busy_sat", a_busy, 1'b0);
    a_v = 1'b1;
`endif

    // GAP=0 instance: codes 1 then 4, no zero cycle between them
    b_valid = 1'b1; b_y = 3'd1; b_v = 1'b1;
    tick(1);
    b_y = 3'd4;
    tick(1);
    b_valid = 1'b0;
    check("g0_d1a", b_d, 8'h02);
    check("g0_done1a", b_done, 1'b0);
    tick(1);
    check("g0_d1b", b_d, 8'h02);
    check("g0_done1b", b_done, 1'b1);
    tick(1);
    check("g0_d2a", b_d, 8'h10);
    check("g0_done2a", b_done, 1'b0);
    tick(1);
    check("g0_d2b", b_d, 8'h10);
    check("g0_done2b", b_done, 1'b1);
    tick(1);
    check("g0_d_end", b_d, 8'h00);
    check("g0_busy_end", b_busy, 1'b0);

    // Reset mid-DRIVE with two codes queued
    a_valid = 1'b1; a_v = 1'b1; a_y = 3'd1;
    tick(1);
    a_y = 3'd2;
    tick(1);
    a_y = 3'd3;
    tick(1);
    a_valid = 1'b0;
    check("mid_d_drive", a_d, 8'h02);
    check("mid_ready_full", a_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_d", a_d, 8'h00);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_done", a_done, 1'b0);
    check("mid_rst_ready", a_ready, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("post_ready", a_ready, 1'b1);
    check("post_busy", a_busy, 1'b0);
    check("post_d", a_d, 8'h00);
    a_valid = 1'b1; a_y = 3'd3; a_v = 1'b1;
    tick(1);
    a_valid = 1'b0;
    check("post_d_E", a_d, 8'h00);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("post_d_hold", a_d, 8'h08);
      check("post_done", a_done, (i == 3));
      tick(1);
    end
    check("post_d_gap", a_d, 8'h00);
    tick(1);
    check("post_busy_idle", a_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder3x8_hold.md
# decoder3x8_hold

Sequential 3-to-8 decoder forming the receive end of the priority-encoder interface: it accepts an encoded index (Y) and valid flag (V) through a valid/ready handshake. Each accepted valid code is buffered in a 2-entry FIFO and drives the matching one-hot line of D for a programmable number of cycles, followed by a programmable idle gap. It sits between the request encoder and the downstream line drivers, converting bursty encoded requests into paced one-hot pulses.

## Interface
- HOLD, 4, cycles each one-hot line is held high; legal range 1..255
- GAP, 1, idle cycles (D = 0) between consecutive codes; legal range 0..15
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream offers {Y,V} this cycle
- in_ready  output  1  block can accept; high when the FIFO is not full
- Y  input  3  encoded index, 0..7
- V  input  1  encoder valid flag; 0 = no request
- D  output  8  one-hot decoded line, registered
- done  output  1  high during the final cycle of each hold period
- busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty
- inv_cnt  output  8  count of accepted V=0 transfers; present only with DEC_INVCNT_EN

## Operation
- **Handshake.**
  - A transfer occurs on any rising edge with in_valid=1 and in_ready=1.
  - in_valid with in_ready=0 is ignored; upstream holds the data.
- **Buffering.**
  - A transfer with V=1 pushes Y into the 2-entry FIFO.
  - A transfer with V=0 is accepted and discarded; the FIFO is unchanged.
  - in_ready = !full, computed from the registered occupancy. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- **FSM states: IDLE, DRIVE, GAP.**
  - IDLE: if the FIFO is non-empty, pop the head, set D = 1<<Y, load hold counter = HOLD-1, go to DRIVE. Otherwise D = 0.
  - DRIVE: D is held. Counter decrements each cycle. When counter = 0, done = 1 for that cycle, and on the next edge:
    - if GAP > 0: D = 0, load gap counter = GAP-1, go to GAP.
    - if GAP = 0 and the FIFO is non-empty: pop, load the new D directly (no zero cycle), stay in DRIVE.
    - if GAP = 0 and the FIFO is empty: D = 0, go to IDLE.
  - GAP: D = 0. Decrement the gap counter; at 0, go to IDLE.
- **Ordering.** Codes are driven strictly in acceptance order. No code is lost or duplicated.
- **Invariant.** D is always 0 or exactly one-hot.
- **Reset.**
  - While rst_n = 0, and immediately on its assertion (including mid-DRIVE): D = 0, done = 0, busy = 0, in_ready = 0, FSM = IDLE, FIFO emptied, counters = 0, inv_cnt = 0.
  - in_ready rises on the first clock edge after rst_n deasserts.

## Timing
- **Latency.** With an empty FIFO and the FSM in IDLE, a transfer on edge E:
  - writes the FIFO on edge E;
  - D is set on edge E+1;
  - D is high for cycles E+1 .. E+HOLD;
  - done is high in the cycle between edges E+HOLD and E+HOLD+1.
- **Throughput.** One code per HOLD+GAP cycles. With GAP > 0, at least one IDLE cycle is added before each pop, so the period is HOLD+GAP+1.
- **Output timing.** All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Configuration
- **DEC_INVCNT_EN defined:**
  - inv_cnt port exists.
  - Increments on every accepted transfer with V=0.
  - Saturates at 255.
  - Cleared by reset.
- **DEC_INVCNT_EN undefined:** the inv_cnt port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset applied mid-run, then released → D=00000000, done=0, busy=0; in_ready=1 one edge after release.
- HOLD=4, GAP=1; single transfer Y=5, V=1 → D=00100000 for exactly 4 cycles starting the edge after acceptance; done high in the 4th cycle; then D=0; busy falls once back in IDLE.
- HOLD=4, GAP=1; in_valid held with codes 0, 7, 3, 6 back-to-back → in_ready drops when the FIFO reaches 2 entries; D sequence is 00000001, 10000000, 00001000, 01000000, each held 4 cycles; no loss or duplication.
- Transfer Y=2, V=0 → D stays 0, busy stays 0, FIFO unchanged. With DEC_INVCNT_EN, inv_cnt goes 0→1; 300 such transfers → inv_cnt = 255.
- HOLD=2, GAP=0 instance; codes 1 then 4 queued → D goes 00000010 → 00010000 with no zero cycle in between; done pulses at the end of each hold period.
- rst_n asserted during DRIVE with 2 codes queued → D=0 asynchronously and the FIFO is emptied; after release, a new transfer Y=3, V=1 yields D=00001000 with the nominal latency.
